// File: rtl/stream_pkg.sv
// Shared stream definitions: mode encodings, round-robin FSM states and
// default channel geometry used by the buffer, mux and MAC blocks.
// No logic; types and constants only.
package stream_pkg;

  localparam logic MODE_SEL = 1'b0;  // explicit channel select
  localparam logic MODE_RR  = 1'b1;  // round-robin bursts

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_NUM_IN = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rr_state_e;

endpackage

// File: rtl/rr_next_valid.sv
// Purpose: find the first asserted valid bit starting at ptr_i, wrapping.
// Latency: combinational.
// Backpressure: none; pure search.
// Ports: valid_i (per-channel valid), ptr_i (search start),
//        found_o (any valid), index_o (first valid at or after ptr_i).
module rr_next_valid #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] valid_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic              found_o,
  output logic [SEL_W-1:0]  index_o
);

  int j;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    j       = 0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NUM_IN;
      if (valid_i[j]) begin
        found_o = 1'b1;
        index_o = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Purpose: registered N:1 stream mux, explicit select or round-robin bursts.
// Latency: 1 cycle from input handshake to out_valid.
// Backpressure: one output slot; holds while out_valid && !out_ready.
// Ports: mode/sel choose the source; in_data/in_valid/in_ready are the
//        per-channel streams; out_data/out_valid/out_ready/out_chan/out_last
//        form the registered output stream (out_last ends an RR burst).
module stream_mux_rr
  import stream_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int NUM_IN    = DEFAULT_NUM_IN,
  parameter int SEL_W     = $clog2(NUM_IN),
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_chan,
  output logic                     out_last
);

  localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W + 1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_IN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  logic [DATA_W-1:0] ch_dat [NUM_IN];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    assign ch_dat[i] = in_data[i*DATA_W +: DATA_W];
  end

  rr_state_e         state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  cur_q, cur_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  chan_q, chan_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;

  logic              srch_found;
  logic [SEL_W-1:0]  srch_idx;
  logic [SEL_W-1:0]  grant;
  logic              grant_vld;
  logic              load;
  logic              xfer;
  logic              is_last;

  rr_next_valid #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_search (
    .valid_i (in_valid),
    .ptr_i   (ptr_q),
    .found_o (srch_found),
    .index_o (srch_idx)
  );

  // An open burst owns the grant regardless of mode, so a mode change
  // mid-burst only takes effect once the FSM is back in IDLE.
  always_comb begin
    grant     = cur_q;
    grant_vld = 1'b0;
    if (state_q == BURST) begin
      grant_vld = 1'b1;
    end else if (mode == MODE_SEL) begin
      grant     = sel;
      grant_vld = ({1'b0, sel} < NUM_IN_L);
    end
  end

  assign load     = !vld_q || out_ready;
  assign xfer     = grant_vld && load && in_valid[grant];
  assign is_last  = (state_q == BURST) && (cnt_q == LAST_CNT);
  assign in_ready = (rst || !grant_vld || !load) ? '0 : (NUM_IN'(1) << grant);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    chan_d  = chan_q;
    vld_d   = vld_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (mode == MODE_RR && srch_found) begin
          cur_d   = srch_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (is_last) begin
            state_d = IDLE;
            ptr_d   = (cur_q == LAST_CH) ? '0 : cur_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      dat_d  = ch_dat[grant];
      chan_d = grant;
      vld_d  = 1'b1;
      last_d = is_last;
    end else if (out_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      dat_q   <= '0;
      chan_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      chan_q  <= chan_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = dat_q;
  assign out_valid = vld_q;
  assign out_chan  = chan_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr (3 channels, 3-beat bursts): directed scenarios
// followed by random traffic, all compared against a transaction-level model.
module tb_stream_mux_rr;
  import stream_pkg::*;

  localparam int NI = 3;
  localparam int BL = 3;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [1:0]     sel;
  logic [NI*DW-1:0] in_data;
  logic [NI-1:0]  in_valid;
  logic [NI-1:0]  in_ready;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_chan;
  logic           out_last;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit       m_busy;
  int       m_cur, m_ptr, m_beats;
  int       m_dat, m_chan;
  bit       m_vld, m_last;

  always #5 clk = ~clk;

  stream_mux_rr #(
    .DATA_W    (DW),
    .NUM_IN    (NI),
    .BURST_LEN (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .out_last  (out_last)
  );

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_cur = 0; m_ptr = 0; m_beats = 0;
    m_dat = 0; m_chan = 0; m_vld = 0; m_last = 0;
  endtask

  // Channel currently allowed to move a beat, or -1.
  function automatic int owner();
    if (m_busy) return m_cur;
    if (mode == MODE_SEL && int'(sel) < NI) return int'(sel);
    return -1;
  endfunction

  function automatic int pred_ready();
    int o;
    o = owner();
    if (rst || o < 0 || !(!m_vld || out_ready)) return 0;
    return 1 << o;
  endfunction

  task automatic model_update();
    int o;
    bit xfer, last;
    bit done;
    if (rst) begin
      model_reset();
      return;
    end
    o    = owner();
    xfer = (pred_ready() & int'(in_valid)) != 0;
    last = m_busy && (m_beats == BL - 1);
    if (xfer) begin
      m_dat  = int'(in_data[o*DW +: DW]);
      m_chan = o;
      m_vld  = 1;
      m_last = last;
    end else if (out_ready) begin
      m_vld = 0;
    end
    if (m_busy) begin
      if (xfer) begin
        m_beats++;
        if (m_beats == BL) begin
          m_busy = 0;
          m_ptr  = (m_cur + 1) % NI;
        end
      end
    end else if (mode == MODE_RR) begin
      done = 0;
      for (int k = 0; k < NI; k++) begin
        int j;
        j = (m_ptr + k) % NI;
        if (!done && in_valid[j]) begin
          done    = 1;
          m_busy  = 1;
          m_cur   = j;
          m_beats = 0;
        end
      end
    end
  endtask

  task automatic compare_outs();
    check("out_valid", int'(out_valid), int'(m_vld));
    check("out_data",  int'(out_data),  m_dat);
    check("out_chan",  int'(out_chan),  m_chan);
    check("out_last",  int'(out_last),  int'(m_last));
  endtask

  // Inputs are set by the caller just after the previous edge.
  task automatic step();
    #1;
    check("in_ready", int'(in_ready), pred_ready());
    @(posedge clk);
    model_update();
    #1;
    compare_outs();
  endtask

  task automatic set_ch(int ch, logic [7:0] v);
    in_data[ch*DW +: DW] = v;
  endtask

  initial begin
    rst = 1'b1; mode = MODE_SEL; sel = 2'd0; in_data = '0;
    in_valid = '0; out_ready = 1'b1;
    model_reset();
    #2;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data",  int'(out_data), 0);
    check("rst_chan",  int'(out_chan), 0);
    check("rst_last",  int'(out_last), 0);
    in_valid = 3'b111;
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    step();
    step();
    rst = 1'b0;
    in_valid = '0;
    step();

    // Explicit select of ch2
    sel = 2'd2; set_ch(2, 8'hA5); in_valid = 3'b100;
    #1;
    check("sel2_in_ready", int'(in_ready), 4);
    step();
    check("sel2_data", int'(out_data), 8'hA5);
    check("sel2_chan", int'(out_chan), 2);
    check("sel2_valid", int'(out_valid), 1);
    check("sel2_last", int'(out_last), 0);

    // Backpressure hold
    sel = 2'd1; set_ch(1, 8'h11); in_valid = 3'b010;
    step();
    set_ch(1, 8'h22); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data", int'(out_data), 8'h11);
      check("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_data", int'(out_data), 8'h22);

    // Out-of-range select drains the slot
    sel = 2'd3; in_valid = 3'b111;
    step();
    check("sel3_in_ready", int'(in_ready), 0);
    check("sel3_drained", int'(out_valid), 0);

    // Round-robin, all channels valid: bubble then 3 beats per channel
    begin
      int ev [12] = '{0,1,1,1,0,1,1,1,0,1,1,1};
      int ec [12] = '{0,0,0,0,0,1,1,1,0,2,2,2};
      int el [12] = '{0,0,0,1,0,0,0,1,0,0,0,1};
      mode = MODE_RR; in_valid = 3'b111;
      for (int i = 0; i < 12; i++) begin
        step();
        check("rr_seq_valid", int'(out_valid), ev[i]);
        if (ev[i] != 0) begin
          check("rr_seq_chan", int'(out_chan), ec[i]);
          check("rr_seq_last", int'(out_last), el[i]);
        end
      end
    end

    // Wrap: burst on ch0 moves ptr to 1, then {ch2,ch0} valid -> ch2 then ch0
    in_valid = 3'b001;
    for (int i = 0; i < 4; i++) step();
    in_valid = 3'b101;
    step();
    step();
    check("wrap_first_chan", int'(out_chan), 2);
    step(); step(); step();
    step();
    check("wrap_second_chan", int'(out_chan), 0);
    check("wrap_second_valid", int'(out_valid), 1);

    // Asynchronous reset one beat into the ch0 burst
    rst = 1'b1;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_data", int'(out_data), 0);
    check("arst_chan", int'(out_chan), 0);
    check("arst_last", int'(out_last), 0);
    model_reset();
    step();
    rst = 1'b0; in_valid = 3'b110;
    step();
    step();
    check("post_rst_chan", int'(out_chan), 1);
    check("post_rst_valid", int'(out_valid), 1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 24) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0)  sel  = 2'($urandom_range(0, 3));
      in_valid  = 3'($urandom);
      in_data   = 24'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare_outs();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised registered N:1 stream multiplexer, successor to the fixed 4x8-bit registered mux.
- Adds per-channel valid/ready handshake, output backpressure and an explicit-select mode.
- Adds a round-robin burst mode so feature-map channels can share one downstream MAC or pool lane.
- Sits between the per-channel buffers and the shared compute lane.

Parameters:
- DATA_W, 8, width of each channel's data.
- NUM_IN, 4, number of input channels (>=2).
- SEL_W, $clog2(NUM_IN), width of sel and out_chan.
- BURST_LEN, 4, beats per grant in round-robin mode (>=1).
- CNT_W, $clog2(BURST_LEN+1), width of the burst counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = explicit select, 1 = round-robin burst.
- sel  in  SEL_W  channel select in mode 0.
- in_data  in  NUM_IN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready, combinational, at most one bit high.
- out_data  out  DATA_W  registered output data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream ready.
- out_chan  out  SEL_W  registered source channel of out_data.
- out_last  out  1  registered; marks the final beat of a round-robin burst; always 0 in mode 0.

Behaviour:
- Reset (async assert, sync release): out_data=0, out_valid=0, out_chan=0, out_last=0, state=IDLE, ptr=0, cnt=0, grant_vld=0. in_ready=0 while rst is high.
- Output stage: one register slot.
  - load = !out_valid || out_ready.
  - Transfer on channel g happens when grant_vld && g==grant && in_valid[g] && load.
  - in_ready[g] = grant_vld && g==grant && load.
  - Transfer: out_data<=in_data[g], out_chan<=g, out_valid<=1, out_last per mode. Latency 1 cycle.
  - No new transfer and out_ready=1: out_valid<=0.
  - out_valid=1 and out_ready=0: every output register holds its value.
- Mode 0 (explicit):
  - grant=sel, grant_vld = (sel<NUM_IN); evaluated every cycle.
  - sel>=NUM_IN: no grant, all in_ready=0, output drains normally.
  - sel change takes effect the same cycle. A beat already in the output register keeps its out_chan.
- Mode 1 (round-robin) FSM, state held in registers:
  - IDLE: grant_vld=0. Search channels ptr, ptr+1, ... mod NUM_IN for the first with in_valid=1.
    - Found: cur<=that index, cnt<=0, go BURST.
    - None: stay IDLE.
    - Each burst costs one bubble cycle in IDLE.
  - BURST: grant=cur, grant_vld=1.
    - Each transfer increments cnt. out_last=1 on the transfer where cnt==BURST_LEN-1.
    - On that transfer: ptr<=(cur+1) mod NUM_IN (wrap NUM_IN-1 -> 0), go IDLE.
    - If in_valid[cur] drops, the grant holds with no timeout; the burst resumes when valid returns.
- Mode switching:
  - mode is sampled only in IDLE, or every cycle while in mode 0.
  - 1->0 during BURST: the burst completes first, then mode 0 applies.
  - 0->1: FSM enters IDLE next cycle with ptr unchanged.
- Simultaneous backpressure and last beat: last beat is not accepted until load=1. cnt and state advance only on an actual transfer.
- Reset mid-burst: partial burst abandoned, counters cleared, out_valid=0 immediately (async).

Decomposition:
- Shared package stream_pkg:
  - mode encodings MODE_SEL=1'b0, MODE_RR=1'b1.
  - state enum {IDLE, BURST}.
  - default DATA_W/NUM_IN constants shared with buffer and MAC blocks.
- One natural sub-module: rr_next_valid. Combinational priority search from ptr with wrap. Inputs valid vector and ptr; outputs found and index.
- Output register and FSM stay in the top module.

Test Plan:
- Mode 0, NUM_IN=4, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_valid=1, out_chan=2, out_last=0.
- Mode 0, out_ready=0 for 3 cycles after beat 8'h11 from ch1 -> out_data/out_valid/out_chan held; in_ready=0. out_ready=1 -> next beat loads the cycle after.
- Mode 1, BURST_LEN=2, all in_valid=1, out_ready=1 -> out_chan sequence 0,0,1,1,2,2,3,3,0. One bubble per burst. out_last=1 on 2nd beat of each burst.
- Mode 1, in_valid=4'b1001, ptr=1 -> ch3 granted first, then wrap to ch0.
- NUM_IN=3, mode 0, sel=3 -> in_ready=3'b000; out_valid drops after draining.
- Mode 1, rst asserted after 1 beat of a BURST_LEN=4 burst -> all outputs 0 asynchronously. After release, IDLE with ptr=0, first grant to lowest valid channel.
